von_neumann_unbiaser: RTL and testbench
=======================================

# von_neumann_unbiaser

Debiasing stage between `ring_oscillator` and `vector_buffer` in the TRNG datapath. It synchronises the free-running oscillator bit into `clk`, pairs successive samples and applies the Von Neumann rule (01→0, 10→1, 00/11 discarded). Each unbiased bit is emitted with a one-cycle valid strobe that feeds the vector buffer's data/valid inputs. A flush input invalidates any half-formed pair when the entropy source selection changes.

## Interface
- `SYNC_STAGES`, 2, flops in the input synchroniser (≥2)
- `REP_CUTOFF`, 32, repetition-count cutoff for the health test (2..255)
- `CNT_W`, 8, width of the discarded-pair counter
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `raw_bit`  in  1  asynchronous raw entropy bit from the oscillator
- `sample_en`  in  1  strobe: take the synchronised bit this cycle
- `flush`  in  1  drop the pending half-pair, clear counters and health status
- `bit_out`  out  1  unbiased bit, meaningful only while `bit_valid`=1
- `bit_valid`  out  1  one-cycle strobe per unbiased bit
- `drop_cnt`  out  CNT_W  saturating count of discarded (equal) pairs
- `health_fail`  out  1  sticky repetition-test failure

## Operation
- `raw_bit` passes through SYNC_STAGES flops; the last stage is the sample `s`.
- FSM states: EMPTY (no pending bit), HALF (first bit held in `first`).
- EMPTY + `sample_en`: `first`←`s`, go to HALF.
- HALF + `sample_en`: if `s`≠`first`: register `bit_out`←`first`, pulse `bit_valid`; if equal: `drop_cnt`++ (saturates at 2^CNT_W−1, never wraps). Go to EMPTY either way.
- `flush`=1: state→EMPTY, `drop_cnt`←0, `health_fail`←0, run counter←0, `bit_valid`←0; any `sample_en` that cycle is ignored (flush wins).
- `sample_en`=0: state, `first` and counters hold; `bit_valid` is 0.
- Synchroniser flops are not cleared by `flush`, only by reset.

## Timing
- Reset (`rst_n`=0 at edge): state EMPTY, sync flops 0, `bit_out`=0, `bit_valid`=0, `drop_cnt`=0, `health_fail`=0. Reset overrides `flush` and `sample_en`.
- Input latency: `raw_bit` change visible at `s` after SYNC_STAGES edges.
- Output latency: `bit_valid`/`bit_out` registered, high for exactly the cycle after the edge that accepts the second sample of a differing pair.
- Back-to-back `sample_en` every cycle: at most one `bit_valid` per two cycles; no stall, no backpressure — the consumer must accept every strobe.
- Reset or flush mid-pair: pending first bit discarded, never emitted.

## Configuration
- `VN_HEALTH_TEST_EN` defined: run counter counts consecutive identical accepted samples (across pair boundaries; reset to 1 on change). When it reaches REP_CUTOFF, `health_fail` sets on the next edge and stays set until flush/reset. While `health_fail`=1, `bit_valid` is forced 0; pairing and `drop_cnt` continue.
- Not defined: no run counter; `health_fail` tied 0; `bit_valid` never gated.

## Structure
- Shared package `trng_pkg`: FSM state enum (EMPTY, HALF), default REP_CUTOFF and CNT_W constants, reused by the future 4-source mux and BIST logic.
- One sub-module: `bit_synchronizer` (parameterised SYNC_STAGES, sync active-low reset), also reusable for `ui_in` controls.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `sample_en`=1, raw toggling → all outputs 0, no `bit_valid`.
- Pairs 0,1 / 1,0 / 1,1 / 0,0 (`sample_en` every cycle, sync delay accounted) → `bit_out` 0 then 1, exactly two strobes, `drop_cnt`=2.
- Flush after first sample of pair: samples 1, flush, then 0,1 → single strobe `bit_out`=0; `drop_cnt`=0.
- Saturation with CNT_W=2: 5 equal pairs → `drop_cnt` 1,2,3,3,3.
- `VN_HEALTH_TEST_EN`, REP_CUTOFF=4: constant raw 1, 4 samples → `health_fail`=1 on the edge after the 4th; then 0,1 pair → no `bit_valid`; flush → `health_fail`=0.
- Simultaneous `flush` and second `sample_en` of a differing pair → no strobe, state EMPTY.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared TRNG datapath types and defaults (pairing FSM states, counter widths).
// Pure declarations: no latency, no flow control.
package trng_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } vn_state_t;

  localparam int REP_CUTOFF_DEF = 32;
  localparam int CNT_W_DEF      = 8;
  localparam int RUN_W          = 8;

endpackage

// File: rtl/von_neumann_unbiaser_if.sv
// Unbiaser port bundle: raw entropy/sample/flush in, unbiased bit strobe and status out.
// No handshake: the consumer must take every bit_valid strobe.
interface von_neumann_unbiaser_if
  import trng_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             raw_bit;
  logic             sample_en;
  logic             flush;
  logic             bit_out;
  logic             bit_valid;
  logic [CNT_W-1:0] drop_cnt;
  logic             health_fail;

  modport master (
    output raw_bit, sample_en, flush,
    input  bit_out, bit_valid, drop_cnt, health_fail
  );

  modport slave (
    input  raw_bit, sample_en, flush,
    output bit_out, bit_valid, drop_cnt, health_fail
  );

endinterface

// File: rtl/von_neumann_unbiaser_sync.sv
// bit_synchronizer: SYNC_STAGES-deep flop chain bringing an async bit into clk.
// Latency SYNC_STAGES edges; no flow control.
module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/von_neumann_unbiaser.sv
// Von Neumann debiaser: pairs synchronised samples, 01->0 / 10->1, equal pairs dropped; one-cycle
// registered strobe, no backpressure. Optional repetition health test under VN_HEALTH_TEST_EN.
module von_neumann_unbiaser
  import trng_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int REP_CUTOFF  = REP_CUTOFF_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  von_neumann_unbiaser_if.slave  vn
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (REP_CUTOFF < 2 || REP_CUTOFF > 255) begin : g_bad_cutoff
    $error("REP_CUTOFF must be within 2..255");
  end

  localparam logic [CNT_W-1:0] DROP_MAX = '1;

  logic             s;
  vn_state_t        state_q, state_d;
  logic             first_q, first_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             hold_off;

  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vn.raw_bit),
    .q     (s)
  );

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    drop_d      = drop_q;
    if (vn.flush) begin
      state_d = EMPTY;
      drop_d  = '0;
    end else if (vn.sample_en) begin
      unique case (state_q)
        EMPTY: begin
          first_d = s;
          state_d = HALF;
        end
        HALF: begin
          if (s != first_q) begin
            bit_out_d   = first_q;
            bit_valid_d = !hold_off;
          end else if (drop_q != DROP_MAX) begin
            drop_d = drop_q + 1'b1;
          end
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      first_q     <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      drop_q      <= drop_d;
    end
  end

`ifdef VN_HEALTH_TEST_EN
  localparam logic [RUN_W-1:0] CUTOFF  = RUN_W'(REP_CUTOFF);
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic             hf_q, hf_d;

  // Run length spans pair boundaries; zero means no sample seen since flush/reset.
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    hf_d   = hf_q | (run_q >= CUTOFF);
    if (vn.flush) begin
      run_d = '0;
      hf_d  = 1'b0;
    end else if (vn.sample_en) begin
      last_d = s;
      if (run_q == '0 || s != last_q) begin
        run_d = RUN_W'(1);
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q  <= '0;
      last_q <= 1'b0;
      hf_q   <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
      hf_q   <= hf_d;
    end
  end

  // Gate on the upcoming status so no strobe escapes on the edge the failure latches.
  assign hold_off       = hf_d;
  assign vn.health_fail = hf_q;
`else
  assign hold_off       = 1'b0;
  assign vn.health_fail = 1'b0;
`endif

  assign vn.bit_out   = bit_out_q;
  assign vn.bit_valid = bit_valid_q;
  assign vn.drop_cnt  = drop_q;

endmodule

// File: tb/tb_von_neumann_unbiaser.sv
// Directed bench for von_neumann_unbiaser with a sample-list reference model checked every cycle.
module tb_von_neumann_unbiaser;

  localparam int N   = 2;
  localparam int CUT = 4;
  localparam int CW  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  von_neumann_unbiaser_if #(.CNT_W(CW)) vn ();

  von_neumann_unbiaser #(
    .SYNC_STAGES (N),
    .REP_CUTOFF  (CUT),
    .CNT_W       (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vn    (vn)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;
  bit strobes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: raw history for the sync delay, list of accepted samples since flush/reset.
  bit hist[$];
  bit acc[$];
  bit m_valid, m_out, m_health;
  int m_drop;

  function automatic int trailing_run();
    int n = 0;
    for (int i = acc.size() - 1; i >= 0; i--) begin
      if (acc[i] != acc[acc.size()-1]) break;
      n++;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    bit s, hn, a, b;
    if (!rst_n) begin
      hist = {};
      for (int i = 0; i < N; i++) hist.push_back(1'b0);
      acc = {};
      m_valid = 0; m_out = 0; m_drop = 0; m_health = 0;
    end else begin
      s = hist[N-1];
      hist.push_front(vn.raw_bit);
      void'(hist.pop_back());
      hn = m_health;
`ifdef VN_HEALTH_TEST_EN
      if (trailing_run() >= CUT) hn = 1;
`endif
      m_valid = 0;
      if (vn.flush) begin
        acc = {};
        m_drop = 0;
        m_health = 0;
      end else begin
        if (vn.sample_en) begin
          acc.push_back(s);
          if (acc.size() % 2 == 0) begin
            a = acc[$-1];
            b = acc[$];
            if (a != b) begin
              if (!hn) begin
                m_valid = 1;
                m_out = a;
              end
            end else if (m_drop < (1 << CW) - 1) begin
              m_drop++;
            end
          end
        end
        m_health = hn;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("bit_valid", vn.bit_valid, m_valid);
      check("drop_cnt", vn.drop_cnt, m_drop);
      check("health_fail", vn.health_fail, m_health);
      if (m_valid) check("bit_out", vn.bit_out, m_out);
      if (vn.bit_valid === 1'b1) strobes.push_back(vn.bit_out);
    end
  end

  task automatic cyc(input logic r, input logic se, input logic fl);
    vn.raw_bit   = r;
    vn.sample_en = se;
    vn.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Bit i of each vector is sample slot i; raw is driven N cycles ahead of its sample_en.
  task automatic run_seq(input logic [15:0] rv, input logic [15:0] sev, input logic [15:0] flv,
                         input int len);
    for (int i = 0; i < len + N + 1; i++) begin
      logic r, se, fl;
      r  = (i < len) ? rv[i] : 1'b0;
      se = (i >= N && i - N < len) ? sev[i-N] : 1'b0;
      fl = (i >= N && i - N < len) ? flv[i-N] : 1'b0;
      cyc(r, se, fl);
    end
  endtask

  initial begin
    int exp_sat[5];
    exp_sat = '{1, 2, 3, 3, 3};
    rst_n = 1'b0;
    vn.raw_bit = 1'b0; vn.sample_en = 1'b0; vn.flush = 1'b0;

    // Reset held with sampling active and raw toggling.
    for (int i = 0; i < 3; i++) begin
      cyc(logic'(i % 2), 1'b1, 1'b0);
      cmp_en = 1'b1;
      check("rst_bit_valid", vn.bit_valid, 0);
      check("rst_bit_out", vn.bit_out, 0);
      check("rst_drop_cnt", vn.drop_cnt, 0);
      check("rst_health", vn.health_fail, 0);
    end
    rst_n = 1'b1;

    // Pairs 01,10,11,00.
    strobes = {};
    run_seq(16'h0036, 16'h00FF, 16'h0000, 8);
    check("pairs_strobes", strobes.size(), 2);
    check("pairs_first", strobes.size() > 0 ? strobes[0] : 2, 0);
    check("pairs_second", strobes.size() > 1 ? strobes[1] : 2, 1);
    check("pairs_drop", vn.drop_cnt, 2);

    // Sample 1, flush, then 0,1.
    strobes = {};
    run_seq(16'h0009, 16'h000D, 16'h0002, 4);
    check("flush_strobes", strobes.size(), 1);
    check("flush_bit", strobes.size() > 0 ? strobes[0] : 2, 0);
    check("flush_drop", vn.drop_cnt, 0);

    // Flush together with the second sample of 0,1; then pair 1,0 must start fresh.
    strobes = {};
    run_seq(16'h0006, 16'h000F, 16'h0002, 4);
    check("simul_strobes", strobes.size(), 1);
    check("simul_bit", strobes.size() > 0 ? strobes[0] : 2, 1);

    // Saturation of a 2-bit drop counter.
    for (int i = 0; i < N; i++) cyc(1'b1, 1'b0, 1'b1);
    for (int p = 0; p < 5; p++) begin
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      check($sformatf("sat_drop_%0d", p), vn.drop_cnt, exp_sat[p]);
    end

`ifdef VN_HEALTH_TEST_EN
    for (int i = 0; i < N; i++) cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
    check("hf_at_4th", vn.health_fail, 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("hf_after_4th", vn.health_fail, 1);
    strobes = {};
    run_seq(16'h0002, 16'h0003, 16'h0000, 2);
    check("hf_gated", strobes.size(), 0);
    check("hf_sticky", vn.health_fail, 1);
    cyc(1'b0, 1'b0, 1'b1);
    check("hf_flush", vn.health_fail, 0);
`endif

    cyc(1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
